// File: rtl/fp_sys_pkg.sv
// Shared constants for the FP-adder board: phase encoding, operand geometry
// and the power-on operand pair used when FPLD_DEFAULT_OPS_EN is defined.
package fp_sys_pkg;

   localparam int unsigned FP_W           = 32;
   localparam int unsigned NIBBLES_PER_OP = 8;

   localparam logic [1:0] PH_LOAD_A = 2'd0;
   localparam logic [1:0] PH_LOAD_B = 2'd1;
   localparam logic [1:0] PH_DONE   = 2'd2;

   typedef enum logic [1:0] {
      ST_LOAD_A = PH_LOAD_A,
      ST_LOAD_B = PH_LOAD_B,
      ST_DONE   = PH_DONE
   } phase_e;

   localparam logic [FP_W-1:0] DEF_OP_A = 32'h6b64b235;
   localparam logic [FP_W-1:0] DEF_OP_B = 32'h6ac49214;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stable-count debounce and a
// single-cycle press pulse on the debounced rising edge.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_noisy,
   output logic db_level,
   output logic press
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic             sync1_q;
   logic             btn_s_q;
   logic             db_q;
   logic             db_dly_q;
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q  <= 1'b0;
         btn_s_q  <= 1'b0;
         db_q     <= 1'b0;
         db_dly_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= btn_noisy;
         btn_s_q  <= sync1_q;
         db_dly_q <= db_q;
         // Any sample matching the accepted level restarts the stability window.
         if (btn_s_q == db_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            db_q  <= ~db_q;
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign db_level = db_q;
   assign press    = db_q & ~db_dly_q;

endmodule

// File: rtl/fp_operand_loader.sv
// Loads two 32-bit FP operands one hex nibble per button press, MSB first.
// Define FPLD_DEFAULT_OPS_EN to power up in DONE holding a default operand pair.
module fp_operand_loader
   import fp_sys_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_noisy,
   input  logic [3:0]  sw,
   output logic [31:0] op_a,
   output logic [31:0] op_b,
   output logic        ops_valid,
   output logic        ops_start,
   output logic [1:0]  phase,
   output logic [2:0]  nib_idx,
   output logic [3:0]  cur_nib
);

`ifdef FPLD_DEFAULT_OPS_EN
   localparam phase_e          RST_PHASE = ST_DONE;
   localparam logic [FP_W-1:0] RST_OP_A  = DEF_OP_A;
   localparam logic [FP_W-1:0] RST_OP_B  = DEF_OP_B;
   localparam logic            RST_VALID = 1'b1;
   localparam logic            RST_BOOT  = 1'b1;
`else
   localparam phase_e          RST_PHASE = ST_LOAD_A;
   localparam logic [FP_W-1:0] RST_OP_A  = '0;
   localparam logic [FP_W-1:0] RST_OP_B  = '0;
   localparam logic            RST_VALID = 1'b0;
   localparam logic            RST_BOOT  = 1'b0;
`endif

   localparam logic [2:0] LAST_NIB = 3'(NIBBLES_PER_OP - 1);

   logic            press;
   logic            db_level_unused;
   phase_e          phase_q;
   logic [FP_W-1:0] op_a_q;
   logic [FP_W-1:0] op_b_q;
   logic [2:0]      nib_idx_q;
   logic [3:0]      cur_nib_q;
   logic            ops_valid_q;
   logic            ops_start_q;
   logic            boot_q;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_btn (
      .clk      (clk),
      .rst      (rst),
      .btn_noisy(btn_noisy),
      .db_level (db_level_unused),
      .press    (press)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase_q     <= RST_PHASE;
         op_a_q      <= RST_OP_A;
         op_b_q      <= RST_OP_B;
         nib_idx_q   <= '0;
         cur_nib_q   <= '0;
         ops_valid_q <= RST_VALID;
         ops_start_q <= 1'b0;
         boot_q      <= RST_BOOT;
      end else begin
         ops_start_q <= boot_q;
         boot_q      <= 1'b0;
         case (phase_q)
            ST_LOAD_A: if (press) begin
               op_a_q    <= {op_a_q[FP_W-5:0], sw};
               cur_nib_q <= sw;
               nib_idx_q <= nib_idx_q + 3'd1;
               if (nib_idx_q == LAST_NIB) phase_q <= ST_LOAD_B;
            end
            ST_LOAD_B: if (press) begin
               op_b_q    <= {op_b_q[FP_W-5:0], sw};
               cur_nib_q <= sw;
               nib_idx_q <= nib_idx_q + 3'd1;
               if (nib_idx_q == LAST_NIB) begin
                  phase_q     <= ST_DONE;
                  ops_valid_q <= 1'b1;
                  ops_start_q <= 1'b1;
               end
            end
            ST_DONE: if (press) begin
               phase_q     <= ST_LOAD_A;
               op_a_q      <= '0;
               op_b_q      <= '0;
               nib_idx_q   <= '0;
               cur_nib_q   <= '0;
               ops_valid_q <= 1'b0;
            end
            // Unused encoding recovers without waiting for a press.
            default: begin
               phase_q     <= ST_LOAD_A;
               op_a_q      <= '0;
               op_b_q      <= '0;
               nib_idx_q   <= '0;
               cur_nib_q   <= '0;
               ops_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign op_a      = op_a_q;
   assign op_b      = op_b_q;
   assign ops_valid = ops_valid_q;
   assign ops_start = ops_start_q;
   assign phase     = phase_q;
   assign nib_idx   = nib_idx_q;
   assign cur_nib   = cur_nib_q;

endmodule

// File: doc/fp_operand_loader.md
Name: fp_operand_loader

Overview:
- Input-side counterpart of the FP-adder board top, which currently drives results out to LEDs and two 7-segment digits.
- Collects the two 32-bit IEEE-754 operands from board inputs: a noisy push-button plus a 4-bit switch bank.
- Captures 16 hex nibbles, MSB first, in order A[31:28] … A[3:0], B[31:28] … B[3:0].
- Presents op_a/op_b with a valid flag to the FP adder. Exposes progress indices so the display logic can echo the digit being entered.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a new button level (10 ms at 50 MHz). Legal range is ≥2.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width. Derived; do not override.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- btn_noisy  input  1  raw push-button, asynchronous to clk, bouncy
- sw  input  4  hex nibble value to load
- op_a  output  32  operand A
- op_b  output  32  operand B
- ops_valid  output  1  high while both operands are complete
- ops_start  output  1  one-cycle pulse on entering DONE
- phase  output  2  0=LOAD_A, 1=LOAD_B, 2=DONE
- nib_idx  output  3  index of next nibble to load (0 = bits 31:28)
- cur_nib  output  4  last nibble captured, for display echo

Behaviour:
- Reset: one clock, clk. rst is asynchronous and active-low; assertion takes effect immediately, regardless of clk.
  - Reset values: op_a=0, op_b=0, ops_valid=0, ops_start=0, phase=LOAD_A, nib_idx=0, cur_nib=0.
  - Synchronizer, debounced level and debounce counter all reset to 0.
- Synchronizer: btn_noisy passes through a 2-FF synchronizer (btn_s).
- Debounce:
  - Counter cnt. If btn_s equals the debounced level db, cnt is cleared to 0.
  - Otherwise cnt increments. When cnt reaches DEBOUNCE_CYCLES-1 while still differing, db toggles and cnt clears.
  - Any bounce back to db restarts the count from 0.
- Press: press = db rising edge (db & ~db_q), a single-cycle event.
  - Release is ignored. Latency from a clean btn_noisy rise to press is 2 + DEBOUNCE_CYCLES + 1 cycles.
- FSM, acting only on press:
  - LOAD_A: reg = {reg[27:0], sw}. sw is sampled in the press cycle (switches are assumed static). cur_nib=sw, nib_idx++.
    - On the nibble that makes nib_idx wrap 7→0, go to LOAD_B.
  - LOAD_B: same shifting into op_b. On wrap, go to DONE; assert ops_start for exactly one cycle and ops_valid=1.
  - DONE: ops_valid held high and op_a/op_b stable.
    - The next press clears op_a, op_b and cur_nib, sets ops_valid=0, nib_idx=0 and phase=LOAD_A. sw is not loaded on that press.
- Ongoing loads: op_a and op_b are visible as they shift. ops_valid=0 in LOAD_A and LOAD_B.
- Unused phase encoding 3: go to LOAD_A with the same clearing as a DONE press, on the next clock.
- Reset mid-entry: all partial nibbles are discarded; there is no resume.
- Button held: produces one press only.

Optional Feature:
- Macro: FPLD_DEFAULT_OPS_EN.
- Defined:
  - Reset loads op_a=32'h6b64b235, op_b=32'h6ac49214, phase=DONE, ops_valid=1.
  - ops_start pulses in the first clock after rst deasserts. A one-bit flag generates this pulse.
  - The first press clears into LOAD_A as usual.
- Undefined: reset values as listed above; no start pulse after reset.

Decomposition:
- Shared package fp_sys_pkg: phase encoding constants (PH_LOAD_A=2'd0, PH_LOAD_B=2'd1, PH_DONE=2'd2), NIBBLES_PER_OP=8, FP_W=32, and the default operand constants above.
- Sub-module btn_debounce (sync + counter + edge): ports clk, rst, btn_noisy, db_level, press; parameter DEBOUNCE_CYCLES. It is reusable for other buttons.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset check: rst low at an arbitrary time mid-cycle → all outputs zero asynchronously; phase=0.
- Bounce rejection: btn_noisy toggles 1,0,1,0 every 2 cycles, then holds 1 for 10 cycles → exactly one press; cur_nib=sw; nib_idx 0→1.
- Full entry: 16 clean presses with sw = 6,b,6,4,b,2,3,5,6,a,c,4,9,2,1,4 → op_a=6b64b235, op_b=6ac49214, phase=2, ops_valid=1, ops_start high exactly one cycle.
- Re-entry from DONE: one more press → op_a=op_b=0, ops_valid=0, nib_idx=0, phase=0; sw not loaded.
- Reset mid-entry: reset asserted after 5 presses → op_a=0 and phase=0; 8 subsequent presses fill op_a from scratch.
- FPLD_DEFAULT_OPS_EN build: release reset → op_a/op_b equal the default constants; ops_valid=1; ops_start pulses once; first press clears to LOAD_A.
